lsu_mem_bridge: RTL

Load/store unit between the core's execute stage and the word-wide data memory. Accepts byte, halfword and word loads and stores with RISC-V size encoding. Drives the memory's word-aligned request/write-enable interface, extracts and extends sub-word load data, and performs read-modify-write for sub-word stores. The memory has no byte enables. Stalls the core through a combinational stall line until each access completes.

---
 rtl/lsu_mem_bridge.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/lsu_mem_bridge.sv
// lsu_mem_bridge: load/store bridge between the execute stage and a word-wide
// data memory without byte enables. Sub-word stores use read-modify-write.
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned H/W
// accesses with a one-cycle lsu_misalign_o pulse and no memory request.
//
// Handshake: the core raises lsu_req_i and holds every lsu_* input stable while
// lsu_stall_o=1; the access is complete in the cycle lsu_stall_o drops (DONE).
module lsu_mem_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_o,
  output logic        lsu_misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] lsu_data_q, lsu_data_d;
  logic        misalign_q, misalign_d;

  // Size decode: [1:0]=0 byte, =1 half, otherwise word; bit 2 selects zero-extend.
  logic        is_byte, is_half, is_word, is_unsigned, misalign_det;
  logic [4:0]  shamt;
  logic [31:0] lane_mask, lane_data, merged, shifted;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign is_byte     = (lsu_size_i[1:0] == 2'b00);
  assign is_half     = (lsu_size_i[1:0] == 2'b01);
  assign is_word     = lsu_size_i[1];
  assign is_unsigned = lsu_size_i[2];

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_det = (is_half & lsu_addr_i[0]) | (is_word & (lsu_addr_i[1:0] != 2'b00));
`else
  assign misalign_det = 1'b0;
`endif

  // Lane selection, load extraction and store merge on the captured read word.
  always_comb begin
    shamt     = is_half ? {lsu_addr_i[1], 4'b0000} : {lsu_addr_i[1:0], 3'b000};
    lane_mask = (is_half ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
    lane_data = (is_half ? (lsu_data_i & 32'h0000_FFFF) : (lsu_data_i & 32'h0000_00FF)) << shamt;
    merged    = (mem_rdata_i & ~lane_mask) | lane_data;
    shifted   = mem_rdata_i >> shamt;
    rd_byte   = shifted[7:0];
    rd_half   = shifted[15:0];
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    lsu_data_d  = lsu_data_q;
    misalign_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          if (misalign_det) begin
            state_d    = DONE;
            misalign_d = 1'b1;
          end else if (lsu_we_i && is_word) begin
            state_d     = WRITE;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {lsu_addr_i[31:2], 2'b00};
            mem_wdata_d = lsu_data_i;
          end else begin
            state_d    = READ;
            mem_req_d  = 1'b1;
            mem_addr_d = {lsu_addr_i[31:2], 2'b00};
          end
        end
      end
      READ: begin
        if (lsu_we_i) begin
          state_d     = WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_wdata_d = merged;
        end else begin
          state_d = DONE;
          if (is_byte)
            lsu_data_d = is_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
          else if (is_half)
            lsu_data_d = is_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
          else
            lsu_data_d = mem_rdata_i;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      lsu_data_q  <= 32'h0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lsu_data_q  <= lsu_data_d;
      misalign_q  <= misalign_d;
    end
  end

  assign lsu_stall_o    = lsu_req_i & (state_q != DONE);
  assign lsu_data_o     = lsu_data_q;
  assign lsu_misalign_o = misalign_q;
  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;

endmodule
